cla_wide_add_seq: RTL and testbench
===================================

# cla_wide_add_seq

Multi-cycle sequencer that reuses one 16-bit carry-lookahead adder slice to add operands of 16×NSEG bits. It issues one 16-bit segment per cycle, least significant first, and chains the carry between segments through a register. It sits between an operand producer and a result consumer, for example the accumulation stage of the Booth multiplier datapath, and uses valid/ready handshakes on both sides.

## Interface
- NSEG, 4, number of 16-bit segments; legal range 1..8; operand width W = 16×NSEG
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  operand request
- in_ready  output  1  sequencer can accept; high only in IDLE
- in_a  input  W  operand A
- in_b  input  W  operand B
- in_cin  input  1  carry-in
- in_sub  input  1  subtract request; present only with CLA_SEQ_SUB_EN
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_sum  output  W  result
- out_cout  output  1  carry out of bit W-1
- out_ovf  output  1  two's-complement overflow
- busy  output  1  high in RUN or DONE

## Operation
- Clock and reset are fixed: single clock clk; rst is asynchronous and active-high.
- Internal datapath: one combinational 16-bit CLA slice (A16, B16, Cin → S16, Cout). Only one slice is instantiated; it is not replicated per segment.
- FSM states are IDLE, RUN and DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid&&in_ready, latch in_a and the effective B (in_b, or ~in_b when subtracting).
  - carry_reg ← in_cin, or 1 when subtracting.
  - seg ← 0; go to RUN.
- **RUN**
  - The slice adds A[16·seg+:16] and Beff[16·seg+:16] with carry_reg.
  - At the clock edge: result[16·seg+:16] ← S16; carry_reg ← Cout; seg ← seg+1.
  - When seg==NSEG-1, go to DONE instead of incrementing.
- **DONE**
  - out_valid=1.
  - out_sum, out_cout and out_ovf are held stable.
  - When out_valid&&out_ready, go to IDLE.
- in_valid is ignored outside IDLE. There is no overlap of transactions.
- out_cout = final carry_reg.
- out_ovf = out_cout XOR (A[W-1] XOR Beff[W-1] XOR out_sum[W-1]), i.e. carry-out XOR carry-in of the MSB.
- All arithmetic is modulo 2^W. The seg counter is ceil(log2(NSEG)) bits wide (minimum 1) and never wraps past NSEG-1.
- **Reset values:** state=IDLE, in_ready=0 while rst is high, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, busy=0, seg=0, carry_reg=0.
- **Reset mid-operation:** asserting rst in RUN or DONE immediately discards the transaction and forces the reset values. No result is ever emitted for that transaction.

## Timing
- Acceptance edge T0: the edge where in_valid&&in_ready.
- Segment i is computed in the cycle after edge T0+i and captured at edge T0+i+1.
- out_valid rises at edge T0+NSEG, so latency is NSEG cycles. With NSEG=1 the latency is 1 cycle.
- Result handshake at edge T1 (out_ready=1 while out_valid=1): state returns to IDLE at T1, and in_ready is high in the following cycle.
- Best-case throughput is one transaction per NSEG+2 cycles.
- in_ready and out_valid are decoded from the state register only. No combinational path exists from in_valid or out_ready to any output.
- out_sum changes only at RUN capture edges. During DONE, out_sum is frozen regardless of how long out_ready stays low.

## Configuration
- Macro: CLA_SEQ_SUB_EN.
- **Defined:**
  - The in_sub port exists.
  - in_sub=1 at acceptance selects A−B: Beff=~in_b and initial carry=1; in_cin is ignored.
  - out_cout=1 means no borrow.
- **Undefined:**
  - No in_sub port.
  - Beff=in_b and initial carry=in_cin always.

## Test plan
- NSEG=4, a=0x0000_0000_0000_FFFF, b=1, cin=0 → out_sum=0x0000_0000_0001_0000, cout=0, ovf=0; out_valid exactly 4 cycles after acceptance.
- a=0xFFFF_FFFF_FFFF_FFFF, b=1 → out_sum=0, cout=1, ovf=0. Carry must ripple through all four segments.
- a=0x7FFF_FFFF_FFFF_FFFF, b=1 → out_sum=0x8000_0000_0000_0000, cout=0, ovf=1.
- Backpressure: out_ready low for 5 cycles after out_valid. out_valid and out_sum must hold, in_ready must stay 0, and a new in_valid with a=0x1234 must be ignored. Raise out_ready: in_ready must return 1 on the next cycle and the next transaction must be computed correctly.
- Assert rst while seg=2 in RUN → out_valid=0, busy=0, out_sum=0 immediately. After release, a=3, b=4 → out_sum=7.
- With CLA_SEQ_SUB_EN: a=5, b=7, sub=1 → out_sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0. Then a=7, b=5 → out_sum=2, cout=1.

Source files
------------

// File: rtl/cla_wide_add_seq.sv
// cla_wide_add_seq: adds two 16*NSEG-bit operands over NSEG cycles by reusing one
// 16-bit carry-lookahead slice, least significant segment first, with the
// inter-segment carry held in a register. Valid/ready handshake on both sides.
// Optional feature: define CLA_SEQ_SUB_EN to add the in_sub port (A - B mode).
module cla_wide_add_seq #(
  parameter int NSEG = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [16*NSEG-1:0]   in_a,
  input  logic [16*NSEG-1:0]   in_b,
  input  logic                 in_cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic                 in_sub,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [16*NSEG-1:0]   out_sum,
  output logic                 out_cout,
  output logic                 out_ovf,
  output logic                 busy
);

  localparam int SW = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [SW-1:0] SEG_LAST = SW'(NSEG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic [NSEG-1:0][15:0]   a_r;
  logic [NSEG-1:0][15:0]   b_r;
  logic [NSEG-1:0][15:0]   sum_r;
  logic                    carry_r;
  logic                    ovf_r;
  logic [SW-1:0]           seg_r;
  logic                    sub_s;
  logic [16:0]             slice_s;

  // 16-bit carry-lookahead slice: 4-bit groups with group generate/propagate,
  // carries inside each group from the local lookahead. Returns {cout, sum}.
  function automatic logic [16:0] cla16(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin);
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;
    g = a & b;
    p = a ^ b;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    gc[0] = cin;
    for (int k = 0; k < 4; k++) begin
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
    for (int k = 0; k < 4; k++) begin
      c[4*k] = gc[k];
      for (int j = 0; j < 3; j++) begin
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      end
    end
    return {gc[4], p ^ c};
  endfunction

`ifdef CLA_SEQ_SUB_EN
  assign sub_s = in_sub;
`else
  assign sub_s = 1'b0;
`endif

  // The single shared slice always works on the segment selected by seg_r.
  assign slice_s = cla16(a_r[seg_r], b_r[seg_r], carry_r);

  // Handshake and status flags are decoded from the state register only.
  assign in_ready  = (state_r == IDLE) && !rst;
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r == RUN) || (state_r == DONE);
  assign out_sum   = sum_r;
  assign out_cout  = carry_r;
  assign out_ovf   = ovf_r;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode: accept in IDLE, step through segments, wait for consumer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (seg_r == SEG_LAST) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Datapath: latch operands on acceptance, capture one segment per RUN cycle,
  // hold everything stable in DONE so the result stays frozen under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      ovf_r   <= 1'b0;
      seg_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r     <= in_a;
            b_r     <= sub_s ? ~in_b : in_b;
            carry_r <= sub_s ? 1'b1 : in_cin;
            seg_r   <= '0;
          end
        end
        RUN: begin
          sum_r[seg_r] <= slice_s[15:0];
          carry_r      <= slice_s[16];
          if (seg_r == SEG_LAST) begin
            // Overflow = carry out of MSB xor carry into MSB.
            ovf_r <= slice_s[16] ^ (a_r[seg_r][15] ^ b_r[seg_r][15] ^ slice_s[15]);
          end else begin
            seg_r <= seg_r + 1'b1;
          end
        end
        default: begin
          carry_r <= carry_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_wide_add_seq.sv
// Self-checking bench for cla_wide_add_seq (NSEG=4): directed cases, backpressure,
// mid-operation reset and random operands against a plain-arithmetic model.
// Define CLA_SEQ_SUB_EN to also exercise subtraction.
module tb_cla_wide_add_seq;

  localparam int NSEG = 4;
  localparam int W    = 16 * NSEG;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_a = '0;
  logic [W-1:0]   in_b = '0;
  logic           in_cin = 1'b0;
`ifdef CLA_SEQ_SUB_EN
  logic           in_sub = 1'b0;
`endif
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   out_sum;
  logic           out_cout;
  logic           out_ovf;
  logic           busy;

  int n_vec = 0;
  int n_err = 0;

  cla_wide_add_seq #(.NSEG(NSEG)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef CLA_SEQ_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} from wide integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    logic [W-1:0] beff;
    logic [W:0]   full;
    logic         ovf;
    beff = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, beff} + (W+1)'(sub ? 1'b1 : cin);
    ovf  = (a[W-1] == beff[W-1]) && (full[W-1] != a[W-1]);
    return {ovf, full};
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub);
    @(negedge clk);
    in_a = a;
    in_b = b;
    in_cin = cin;
`ifdef CLA_SEQ_SUB_EN
    in_sub = sub;
`endif
    in_valid = 1'b1;
    chk("in_ready_idle", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("busy_run", busy, 1'b1);
  endtask

  task automatic wait_result(input logic [W+1:0] exp);
    int cyc = 0;
    while (!out_valid && cyc < NSEG + 8) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, NSEG);
    chk("sum", out_sum, exp[W-1:0]);
    chk("cout", out_cout, exp[W]);
    chk("ovf", out_ovf, exp[W+1]);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_drop", out_valid, 1'b0);
    chk("in_ready_back", in_ready, 1'b1);
  endtask

  task automatic do_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
    logic [W+1:0] exp;
    exp = model(a, b, cin, sub);
    issue(a, b, cin, sub);
    wait_result(exp);
    release_result();
  endtask

  initial begin
    logic [W+1:0] exp;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_sum", out_sum, '0);
    chk("rst_cout", out_cout, 1'b0);
    chk("rst_ovf", out_ovf, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1'b1);

    // Directed cases with hand-derived expectations
    issue(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
    wait_result({1'b0, 1'b0, 64'h0000_0000_0001_0000});
    release_result();
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    wait_result({1'b0, 1'b1, 64'h0});
    release_result();
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    wait_result({1'b1, 1'b0, 64'h8000_0000_0000_0000});
    release_result();
    do_txn(64'h0, 64'h0, 1'b1, 1'b0);

    // Backpressure: result frozen, new requests ignored
    exp = model(64'h1111_2222_3333_4444, 64'h0F0F_F0F0_8888_CCCC, 1'b1, 1'b0);
    issue(64'h1111_2222_3333_4444, 64'h0F0F_F0F0_8888_CCCC, 1'b1, 1'b0);
    wait_result(exp);
    in_a = 64'h1234;
    in_b = 64'h0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_sum_hold", out_sum, exp[W-1:0]);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    release_result();
    do_txn(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0);

    // Reset while seg==2 in RUN
    issue(64'h0005_0004_0003_0002, 64'h1, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_sum", out_sum, '0);
    chk("mid_rst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (NSEG + 2) @(negedge clk);
    chk("no_stale_result", out_valid, 1'b0);
    do_txn(64'h3, 64'h4, 1'b0, 1'b0);

`ifdef CLA_SEQ_SUB_EN
    // Subtraction: cout=1 means no borrow
    issue(64'h5, 64'h7, 1'b0, 1'b1);
    wait_result({1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
    release_result();
    issue(64'h7, 64'h5, 1'b1, 1'b1);
    wait_result({1'b0, 1'b1, 64'h2});
    release_result();
`endif

    // Random operands, with occasional all-ones to force long carry chains
    for (int n = 0; n < 24; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? '1 : rnd();
      rb = ($urandom_range(0, 3) == 0) ? W'(1) : rnd();
`ifdef CLA_SEQ_SUB_EN
      do_txn(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`else
      do_txn(ra, rb, 1'($urandom_range(0, 1)), 1'b0);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
